// File: rtl/pipeline_control.sv
// Stall/flush sequencer for a 5-stage in-order pipeline: Mealy control of the
// stage register enables and bubble loads, plus mul/div timeout and statistics.
module pipeline_control #(
  parameter int unsigned MULDIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use_stall,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        muldiv_start,
  input  logic        muldiv_done,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        halted,
  output logic        muldiv_err,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MULDIV_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MULDIV_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEM_WAIT,
    S_MULDIV_WAIT,
    S_HALTED
  } state_e;

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [31:0]         stall_q, flush_q;

  // en_c = {pc, if_id, id_ex, ex_mem, mem_wb}; fl_c = {if_id, id_ex, ex_mem, mem_wb}
  logic [4:0]          en_c;
  logic [3:0]          fl_c;
  logic                eval_c, skip_p2_c, skip_p3_c, p4_c;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    en_c      = 5'b11111;
    fl_c      = 4'b0000;
    state_d   = state_q;
    err_d     = err_q;
    wait_d    = wait_q;
    eval_c    = 1'b0;
    skip_p2_c = 1'b0;
    skip_p3_c = 1'b0;
    p4_c      = 1'b0;

    case (state_q)
      S_RUN: eval_c = 1'b1;
      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          en_c = 5'b00001;
          fl_c = 4'b0001;
        end else begin
          eval_c    = 1'b1;
          skip_p2_c = 1'b1;
        end
      end
      S_MULDIV_WAIT: begin
        if (!muldiv_done) begin
          en_c   = 5'b00011;
          fl_c   = 4'b0010;
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d >= WAIT_LIMIT) begin
            state_d = S_HALTED;
            err_d   = 1'b1;
          end
        end else begin
          eval_c    = 1'b1;
          skip_p2_c = 1'b1;
          skip_p3_c = 1'b1;
        end
      end
      default: begin
        en_c = 5'b00000;
        if (resume) begin
          state_d = S_RUN;
          err_d   = 1'b0;
        end
      end
    endcase

    // Shared RUN priority chain, also used on MEM/MULDIV completion cycles
    if (eval_c) begin
      state_d = S_RUN;
      if (halt_req) begin
        en_c    = 5'b00000;
        state_d = S_HALTED;
      end else if (!skip_p2_c && dmem_req && !dmem_ready) begin
        en_c    = 5'b00001;
        fl_c    = 4'b0001;
        state_d = S_MEM_WAIT;
      end else if (!skip_p3_c && muldiv_start) begin
        en_c    = 5'b00011;
        fl_c    = 4'b0010;
        wait_d  = '0;
        state_d = S_MULDIV_WAIT;
      end else if (branch_taken) begin
        fl_c = 4'b1100;
        p4_c = 1'b1;
      end else if (load_use_stall) begin
        en_c = 5'b00111;
        fl_c = 4'b0100;
      end else if (!imem_ready) begin
        en_c = 5'b01111;
        fl_c = 4'b1000;
      end
    end
  end

  // Reset forces every stage register to a bubble regardless of state
  always_comb begin
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = 5'b00000;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
      halted = 1'b0;
    end else begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = en_c;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = fl_c;
      halted = (state_q == S_HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RUN;
      err_q   <= 1'b0;
      wait_q  <= '0;
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      if (!en_c[4] && state_q != S_HALTED) stall_q <= sat_inc(stall_q);
      if (p4_c) flush_q <= sat_inc(flush_q);
    end
  end

  assign muldiv_err  = err_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed scoreboard bench for pipeline_control: the driver queues expected
// outputs per cycle, the negedge monitor pops and compares.
module tb_pipeline_control;

  logic clk = 1'b1;
  logic reset, load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready;
  logic muldiv_start, muldiv_done, halt_req, resume;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic halted, muldiv_err;
  logic [31:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_control #(.MULDIV_TIMEOUT(40)) dut (
    .clk(clk), .reset(reset), .load_use_stall(load_use_stall),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_req(dmem_req),
    .dmem_ready(dmem_ready), .muldiv_start(muldiv_start), .muldiv_done(muldiv_done),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halted(halted),
    .muldiv_err(muldiv_err), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Input bits: {reset, lus, br, imem, dreq, drdy, mstart, mdone, halt, resume}
  localparam logic [9:0] RST = 10'h200, LUS = 10'h100, BR = 10'h080, IMEM = 10'h040;
  localparam logic [9:0] DREQ = 10'h020, DRDY = 10'h010, MST = 10'h008, MDN = 10'h004;
  localparam logic [9:0] HLT = 10'h002, RSM = 10'h001;

  // Output bits: {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem,mem_wb flush, halted, err}
  localparam logic [10:0] O_RUN = {5'b11111, 4'b0000, 2'b00};
  localparam logic [10:0] O_P2  = {5'b00001, 4'b0001, 2'b00};
  localparam logic [10:0] O_P3  = {5'b00011, 4'b0010, 2'b00};
  localparam logic [10:0] O_P4  = {5'b11111, 4'b1100, 2'b00};
  localparam logic [10:0] O_P5  = {5'b00111, 4'b0100, 2'b00};
  localparam logic [10:0] O_P6  = {5'b01111, 4'b1000, 2'b00};
  localparam logic [10:0] O_P1  = 11'b000_0000_0000;
  localparam logic [10:0] O_HLT = 11'b000_0000_0010;
  localparam logic [10:0] O_HLE = 11'b000_0000_0011;
  localparam logic [10:0] O_P3E = {5'b00011, 4'b0010, 2'b01};
  localparam logic [10:0] O_RST = {5'b00000, 4'b1111, 2'b00};

  typedef struct {
    logic [10:0] out;
    logic [31:0] sc;
    logic [31:0] fc;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic cyc(input logic [9:0] in, input logic [10:0] out, input int sc,
                     input int fc, input bit chk, input string nm);
    exp_t e;
    {reset, load_use_stall, branch_taken, imem_ready, dmem_req, dmem_ready,
     muldiv_start, muldiv_done, halt_req, resume} = in;
    e.out = out; e.sc = sc; e.fc = fc; e.chk = chk; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [10:0] act, msk;
      e   = q.pop_front();
      act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted, muldiv_err};
      msk = e.chk ? 11'h7FF : 11'h7FE;
      n_cmp++;
      if ((act & msk) !== (e.out & msk)) begin
        n_err++;
        $display("FAIL %s outputs: got %b expected %b", e.name, act, e.out);
      end
      if (e.chk) begin
        n_cmp++;
        if (stall_count !== e.sc) begin
          n_err++;
          $display("FAIL %s stall_count: got %0d expected %0d", e.name, stall_count, e.sc);
        end
        n_cmp++;
        if (flush_count !== e.fc) begin
          n_err++;
          $display("FAIL %s flush_count: got %0d expected %0d", e.name, flush_count, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: first cycle has no prior edge, so counters and err are not checked
    cyc(RST | IMEM, O_RST, 0, 0, 0, "reset_c1");
    cyc(RST | IMEM, O_RST, 0, 0, 1, "reset_c2");
    cyc(IMEM,        O_RUN, 0, 0, 1, "idle_after_reset");
    cyc(IMEM | RSM,  O_RUN, 0, 0, 1, "resume_ignored_in_run");

    // Load-use stall for one cycle
    cyc(IMEM | LUS,  O_P5,  0, 0, 1, "load_use");
    cyc(IMEM,        O_RUN, 1, 0, 1, "after_load_use");

    // Branch overrides load-use
    cyc(IMEM | BR | LUS, O_P4, 1, 0, 1, "branch_over_lus");
    cyc(IMEM,            O_RUN, 1, 1, 1, "after_branch");

    // Fetch not ready
    cyc(10'h000, O_P6,  1, 1, 1, "imem_not_ready");
    cyc(IMEM,    O_RUN, 2, 1, 1, "after_imem");

    // Data memory wait: 3 stalled cycles then completion
    cyc(IMEM | DREQ,        O_P2,  2, 1, 1, "dmem_entry");
    cyc(IMEM | DREQ,        O_P2,  3, 1, 1, "dmem_wait1");
    cyc(IMEM | DREQ,        O_P2,  4, 1, 1, "dmem_wait2");
    cyc(IMEM | DREQ | DRDY, O_RUN, 5, 1, 1, "dmem_done");
    cyc(IMEM,               O_RUN, 5, 1, 1, "after_dmem");

    // Mul/div: entry plus 5 waits, then done
    cyc(IMEM | MST, O_P3, 5, 1, 1, "muldiv_entry");
    for (int k = 1; k <= 5; k++) cyc(IMEM | MST, O_P3, 5 + k, 1, 1, "muldiv_wait");
    cyc(IMEM | MDN, O_RUN, 11, 1, 1, "muldiv_done");
    cyc(IMEM,       O_RUN, 11, 1, 1, "after_muldiv");

    // halt_req taken on the MEM_WAIT completion cycle; HALTED ignores inputs
    cyc(IMEM | DREQ,              O_P2,  11, 1, 1, "dmem_entry2");
    cyc(IMEM | DREQ | DRDY | HLT, O_P1,  12, 1, 1, "halt_on_dmem_done");
    cyc(IMEM | BR | LUS | MST,    O_HLT, 13, 1, 1, "halted_ignores");
    cyc(IMEM | RSM,               O_HLT, 13, 1, 1, "resume_cycle");
    cyc(IMEM,                     O_RUN, 13, 1, 1, "run_after_resume");

    // Timeout: 40 waits with done low (dmem_req ignored), then HALTED with err
    cyc(IMEM | MST, O_P3, 13, 1, 1, "timeout_entry");
    for (int k = 1; k <= 40; k++)
      cyc(IMEM | DREQ, O_P3, 13 + k, 1, 1, "timeout_wait");
    cyc(IMEM,       O_HLE, 54, 1, 1, "timeout_halted");
    cyc(IMEM | MDN, O_HLE, 54, 1, 1, "timeout_halted2");
    cyc(IMEM | RSM, O_HLE, 54, 1, 1, "timeout_resume");
    cyc(IMEM,       O_RUN, 54, 1, 1, "after_timeout_resume");

    // Reset mid MULDIV_WAIT
    cyc(IMEM | MST,       O_P3,  54, 1, 1, "rst_muldiv_entry");
    cyc(IMEM,             O_P3,  55, 1, 1, "rst_muldiv_wait");
    cyc(RST | IMEM,       O_RST, 56, 1, 1, "reset_mid_muldiv");
    cyc(RST | IMEM,       O_RST, 0, 0, 1, "reset_mid_muldiv2");
    cyc(IMEM,             O_RUN, 0, 0, 1, "run_after_reset");
    cyc(IMEM | MDN,       O_RUN, 0, 0, 1, "stray_done_in_run");

    // halt_req in RUN
    cyc(IMEM | HLT | BR,  O_P1,  0, 0, 1, "halt_in_run");
    cyc(IMEM,             O_HLT, 1, 0, 1, "halted_state");
    cyc(IMEM | RSM,       O_HLT, 1, 0, 1, "halted_resume");
    cyc(IMEM,             O_RUN, 1, 0, 1, "final_run");

    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
